// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: instruction field positions, control-word bit indices and the bubble constant
package decode_stage_pkg;
    localparam int CTRL_W        = 8;
    localparam int CTRL_MEMREAD  = 0;
    localparam int CTRL_REGWRITE = 1;
    localparam int RD_LSB        = 8;
    localparam int RS_LSB        = 5;
    localparam int RT_LSB        = 2;
    localparam int IMM_W         = 5;
    localparam logic [CTRL_W-1:0] BUBBLE = '0;

    function automatic logic [15:0] signExtImm(input logic [IMM_W-1:0] imm);
        return {{(16-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction
endpackage

// File: rtl/decode_stage_reg_file.sv
// reg_file: 16-bit register file, 2 combinational read ports, 1 write port with write-before-read bypass, r0 = 0
//   clk, rst              clock, synchronous active-high reset (clears every register)
//   wbEn, wbAddr, wbData  write port; writes to r0 are dropped
//   rdAddrA/B, rdDataA/B  read ports
module reg_file #(
    parameter int NREGS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wbEn,
    input  logic [2:0]  wbAddr,
    input  logic [15:0] wbData,
    input  logic [2:0]  rdAddrA,
    input  logic [2:0]  rdAddrB,
    output logic [15:0] rdDataA,
    output logic [15:0] rdDataB
);
    logic [15:0] regs [NREGS];
    logic        wr;

    assign wr = wbEn && wbAddr != 3'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr) begin
            regs[wbAddr] <= wbData;
        end
    end

    assign rdDataA = rdAddrA == 3'd0 ? '0 : (wr && wbAddr == rdAddrA) ? wbData : regs[rdAddrA];
    assign rdDataB = rdAddrB == 3'd0 ? '0 : (wr && wbAddr == rdAddrB) ? wbData : regs[rdAddrB];
endmodule

// File: rtl/decode_stage.sv
// decode_stage: register read, immediate sign-extension, load-use hazard detection and the decode pipeline register
//   NextPCIn, InstructIn, CtrlIn  fetch register outputs and decoded control word (bit0 MemRead, bit1 RegWrite)
//   UsesRs, UsesRt                instruction reads rs / rt
//   Flush, ExtStall               kill decode / hold decode register (Flush wins)
//   WbEn, WbAddr, WbData          register file writeback port
//   Stall                         combinational load-use stall back to fetch
//   NextPCOut..CtrlOut            registered decode results for execute; CtrlOut = 0 is a bubble
module decode_stage #(
    parameter int CTRL_W = decode_stage_pkg::CTRL_W,
    parameter int NREGS  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       NextPCIn,
    input  logic [15:0]       InstructIn,
    input  logic [CTRL_W-1:0] CtrlIn,
    input  logic              UsesRs,
    input  logic              UsesRt,
    input  logic              Flush,
    input  logic              ExtStall,
    input  logic              WbEn,
    input  logic [2:0]        WbAddr,
    input  logic [15:0]       WbData,
    output logic              Stall,
    output logic [15:0]       NextPCOut,
    output logic [15:0]       RsData,
    output logic [15:0]       RtData,
    output logic [15:0]       Imm,
    output logic [2:0]        RdOut,
    output logic [CTRL_W-1:0] CtrlOut
);
    import decode_stage_pkg::*;

    logic [2:0]  rdAddr, rsAddr, rtAddr;
    logic [15:0] rsRead, rtRead;
    logic        unusedOpBits;

    assign rdAddr       = InstructIn[RD_LSB +: 3];
    assign rsAddr       = InstructIn[RS_LSB +: 3];
    assign rtAddr       = InstructIn[RT_LSB +: 3];
    assign unusedOpBits = ^InstructIn[15:11];

    reg_file #(.NREGS(NREGS)) regFile (
        .clk(clk), .rst(rst),
        .wbEn(WbEn), .wbAddr(WbAddr), .wbData(WbData),
        .rdAddrA(rsAddr), .rdAddrB(rtAddr),
        .rdDataA(rsRead), .rdDataB(rtRead)
    );

    // A load sitting in the decode register cannot forward in time; the next user must wait one bubble.
    assign Stall = !Flush && CtrlOut[CTRL_MEMREAD] && RdOut != 3'd0 &&
                   ((UsesRs && rsAddr == RdOut) || (UsesRt && rtAddr == RdOut));

    always_ff @(posedge clk) begin
        if (rst) begin
            NextPCOut <= '0;
            RsData    <= '0;
            RtData    <= '0;
            Imm       <= '0;
            RdOut     <= '0;
            CtrlOut   <= CTRL_W'(BUBBLE);
        end else if (Flush || !ExtStall) begin
            NextPCOut <= NextPCIn;
            RsData    <= rsRead;
            RtData    <= rtRead;
            Imm       <= signExtImm(InstructIn[IMM_W-1:0]);
            RdOut     <= rdAddr;
            CtrlOut   <= (Flush || Stall) ? CTRL_W'(BUBBLE) : CtrlIn;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed self-checking bench for decode_stage
module tb_decode_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] NextPCIn, InstructIn, WbData;
    logic [7:0]  CtrlIn;
    logic        UsesRs, UsesRt, Flush, ExtStall, WbEn;
    logic [2:0]  WbAddr;
    logic        Stall;
    logic [15:0] NextPCOut, RsData, RtData, Imm;
    logic [2:0]  RdOut;
    logic [7:0]  CtrlOut;
    int          checks = 0;
    int          failures = 0;

    decode_stage dut (
        .clk(clk), .rst(rst), .NextPCIn(NextPCIn), .InstructIn(InstructIn), .CtrlIn(CtrlIn),
        .UsesRs(UsesRs), .UsesRt(UsesRt), .Flush(Flush), .ExtStall(ExtStall),
        .WbEn(WbEn), .WbAddr(WbAddr), .WbData(WbData), .Stall(Stall),
        .NextPCOut(NextPCOut), .RsData(RsData), .RtData(RtData), .Imm(Imm),
        .RdOut(RdOut), .CtrlOut(CtrlOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ins(input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] rt);
        return {5'b0, rd, rs, rt, 2'b0};
    endfunction

    initial begin
        rst = 1'b1; NextPCIn = '0; InstructIn = '0; CtrlIn = '0; UsesRs = 1'b0; UsesRt = 1'b0;
        Flush = 1'b0; ExtStall = 1'b0; WbEn = 1'b0; WbAddr = '0; WbData = '0;
        tick(); tick();
        check("rst_ctrl", 16'(CtrlOut), 16'h0);
        check("rst_pc", NextPCOut, 16'h0);
        check("rst_rs", RsData, 16'h0);
        check("rst_rt", RtData, 16'h0);
        check("rst_imm", Imm, 16'h0);
        check("rst_rd", 16'(RdOut), 16'h0);
        check("rst_stall", 16'(Stall), 16'h0);
        rst = 1'b0;
        for (int k = 1; k < 8; k++) begin
            InstructIn = ins(3'd0, 3'(k), 3'(k));
            tick();
            check($sformatf("rst_r%0d_rs", k), RsData, 16'h0);
            check($sformatf("rst_r%0d_rt", k), RtData, 16'h0);
        end

        // writeback bypass into r3
        WbEn = 1'b1; WbAddr = 3'd3; WbData = 16'hBEEF;
        InstructIn = ins(3'd1, 3'd3, 3'd0); CtrlIn = 8'h02; NextPCIn = 16'h0010;
        tick();
        check("byp_rs", RsData, 16'hBEEF);
        check("byp_pc", NextPCOut, 16'h0010);
        check("byp_ctrl", 16'(CtrlOut), 16'h0002);
        check("byp_rd", 16'(RdOut), 16'h0001);
        WbEn = 1'b0;
        InstructIn = ins(3'd1, 3'd0, 3'd3);
        tick();
        check("stored_rt", RtData, 16'hBEEF);
        WbEn = 1'b1; WbAddr = 3'd0; WbData = 16'h1234;
        InstructIn = ins(3'd1, 3'd0, 3'd0);
        tick();
        check("r0_byp", RsData, 16'h0);
        WbEn = 1'b0;
        tick();
        check("r0_kept", RsData, 16'h0);

        // load-use on rs
        InstructIn = ins(3'd2, 3'd0, 3'd0); CtrlIn = 8'h03;
        tick();
        check("ld_ctrl", 16'(CtrlOut), 16'h0003);
        InstructIn = ins(3'd4, 3'd2, 3'd0); CtrlIn = 8'h02; UsesRs = 1'b1;
        #1 check("lu_stall", 16'(Stall), 16'h1);
        tick();
        check("lu_bubble", 16'(CtrlOut), 16'h0);
        check("lu_stall_off", 16'(Stall), 16'h0);
        tick();
        check("lu_issue_ctrl", 16'(CtrlOut), 16'h0002);
        check("lu_issue_rd", 16'(RdOut), 16'h0004);

        // load then non-user of rs
        InstructIn = ins(3'd2, 3'd0, 3'd0); CtrlIn = 8'h03; UsesRs = 1'b0;
        tick();
        InstructIn = ins(3'd4, 3'd2, 3'd2); CtrlIn = 8'h02;
        #1 check("nouse_stall", 16'(Stall), 16'h0);
        tick();
        check("nouse_ctrl", 16'(CtrlOut), 16'h0002);

        // load-use on rt
        InstructIn = ins(3'd5, 3'd0, 3'd0); CtrlIn = 8'h03;
        tick();
        InstructIn = ins(3'd6, 3'd0, 3'd5); CtrlIn = 8'h02; UsesRt = 1'b1;
        #1 check("rt_stall", 16'(Stall), 16'h1);
        // flush during the hazard
        Flush = 1'b1;
        #1 check("flush_stall", 16'(Stall), 16'h0);
        tick();
        check("flush_ctrl", 16'(CtrlOut), 16'h0);
        UsesRt = 1'b0;
        Flush = 1'b1; ExtStall = 1'b1; CtrlIn = 8'h02;
        tick();
        check("flush_ext_ctrl", 16'(CtrlOut), 16'h0);
        Flush = 1'b0; ExtStall = 1'b0;

        // external stall holds everything
        InstructIn = ins(3'd6, 3'd3, 3'd0); CtrlIn = 8'h02; NextPCIn = 16'h0020;
        tick();
        ExtStall = 1'b1;
        InstructIn = ins(3'd1, 3'd0, 3'd0); CtrlIn = 8'h80; NextPCIn = 16'h0030;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("hold_ctrl", 16'(CtrlOut), 16'h0002);
            check("hold_pc", NextPCOut, 16'h0020);
            check("hold_rd", 16'(RdOut), 16'h0006);
            check("hold_rs", RsData, 16'hBEEF);
        end
        ExtStall = 1'b0;
        tick();
        check("rel_ctrl", 16'(CtrlOut), 16'h0080);
        check("rel_pc", NextPCOut, 16'h0030);
        check("rel_rd", 16'(RdOut), 16'h0001);

        // immediate sign extension
        InstructIn = 16'h0010; CtrlIn = 8'h02;
        tick();
        check("imm_neg", Imm, 16'hFFF0);
        InstructIn = 16'h000F;
        tick();
        check("imm_pos", Imm, 16'h000F);

        // reset mid-stall, and register file cleared
        InstructIn = ins(3'd2, 3'd0, 3'd0); CtrlIn = 8'h03;
        tick();
        InstructIn = ins(3'd4, 3'd2, 3'd0); CtrlIn = 8'h02; UsesRs = 1'b1;
        #1 check("pre_rst_stall", 16'(Stall), 16'h1);
        rst = 1'b1;
        tick();
        check("rst_mid_stall", 16'(Stall), 16'h0);
        check("rst_mid_ctrl", 16'(CtrlOut), 16'h0);
        rst = 1'b0; UsesRs = 1'b0;
        InstructIn = ins(3'd1, 3'd3, 3'd0);
        tick();
        check("rst_r3_clear", RsData, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
